// File: rtl/ucaspian_dendrite_multi.sv
// Dendrite charge accumulator with ping-pong banks and grouped flush.
// Saturating RMW pipe with forwarding, zero-skip flush, clear sweep.
module ucaspian_dendrite_multi #(
  parameter int ADDR_W    = 8,
  parameter int IN_W      = 9,
  parameter int ACC_W     = 16,
  parameter int GROUP_W   = 4,
  parameter int SATURATE  = 1,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_act,
  output logic              clear_done,
  input  logic              next_step,
  output logic              step_done,
  output logic              step_err,
  input  logic [ADDR_W-1:0] dend_addr,
  input  logic [IN_W-1:0]   dend_charge,
  input  logic              dend_vld,
  output logic              dend_rdy,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [ACC_W-1:0]  neuron_charge,
  output logic              neuron_vld,
  input  logic              neuron_rdy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int GRP_W = ADDR_W - GROUP_W;
  localparam int NG    = 2 ** GRP_W;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_RD, S_PRES, S_DONE
  } state_t;

  logic [ACC_W-1:0] mem [2][DEPTH];

  logic              sel;
  logic              out_bank;
  logic              rdy_q;
  logic              swap_d;
  logic              accept;
  logic              swap;
  logic              pipe_empty;
  logic              out_busy;

  logic              s1_vld;
  logic              s1_bank;
  logic [ADDR_W-1:0] s1_addr;
  logic [IN_W-1:0]   s1_chg;
  logic              s2_vld;
  logic              s2_bank;
  logic [ADDR_W-1:0] s2_addr;
  logic [IN_W-1:0]   s2_chg;
  logic [ACC_W-1:0]  s2_old;
  logic [ACC_W:0]    s2_wide;
  logic [ACC_W-1:0]  s2_sum;

  logic [NG-1:0]     act [2];
  logic [NG-1:0]     mask;
  logic [NG-1:0]     scan_vec;
  logic              found;
  logic [GRP_W-1:0]  lo;

  state_t            state;
  state_t            state_nx;
  logic [GRP_W-1:0]  grp;
  logic [GRP_W-1:0]  grp_nx;
  logic [GROUP_W-1:0] idx;
  logic [GROUP_W-1:0] idx_nx;
  logic [ACC_W-1:0]  fl_data;
  logic              fl_we;
  logic              mask_set;
  logic              adv;

  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_fin;

  assign out_bank   = ~sel;
  assign accept     = dend_vld & dend_rdy;
  assign pipe_empty = ~s1_vld & ~s2_vld;
  assign step_done  = ((state == S_DONE) || (state == S_IDLE)) & pipe_empty;
  assign swap       = next_step & step_done & ~clear_act;
  assign dend_rdy   = rdy_q & ~clear_act & ~next_step & ~swap_d;
  assign out_busy   = (s1_vld & (s1_bank != sel)) |
                      (s2_vld & (s2_bank != sel));

  assign neuron_addr   = {grp, idx};
  assign neuron_charge = fl_data;

  always_comb begin
    s2_wide = {{(ACC_W+1-IN_W){s2_chg[IN_W-1]}}, s2_chg}
            + {s2_old[ACC_W-1], s2_old};
    s2_sum  = s2_wide[ACC_W-1:0];
    if ((SATURATE != 0) && (s2_wide[ACC_W] != s2_wide[ACC_W-1]))
      s2_sum = s2_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q    <= 1'b0;
      swap_d   <= 1'b0;
      step_err <= 1'b0;
      sel      <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      swap_d   <= next_step;
      step_err <= next_step & ~step_done;
      if (swap)
        sel <= ~sel;
    end
  end

  // Back-to-back hit: the stage ahead has not written yet, take its sum.
  always_ff @(posedge clk) begin
    if (reset || clear_act) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld  <= accept;
      s1_bank <= sel;
      s1_addr <= dend_addr;
      s1_chg  <= dend_charge;
      s2_vld  <= s1_vld;
      s2_bank <= s1_bank;
      s2_addr <= s1_addr;
      s2_chg  <= s1_chg;
      if (s2_vld && (s2_addr == s1_addr) && (s2_bank == s1_bank))
        s2_old <= s2_sum;
      else
        s2_old <= mem[s1_bank][s1_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (clear_act && !clr_fin) begin
      mem[0][clr_cnt] <= '0;
      mem[1][clr_cnt] <= '0;
    end else if (!reset) begin
      if (s2_vld)
        mem[s2_bank][s2_addr] <= s2_sum;
      if (fl_we)
        mem[out_bank][{grp, idx}] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RD)
      fl_data <= mem[out_bank][{grp, idx}];
  end

  always_ff @(posedge clk) begin
    if (reset || clear_act) begin
      act[0] <= '0;
      act[1] <= '0;
      mask   <= '0;
    end else begin
      if (swap) begin
        act[out_bank] <= '0;
        mask          <= '0;
      end
      if (s2_vld)
        act[s2_bank][s2_addr[ADDR_W-1:GROUP_W]] <= 1'b1;
      if (mask_set)
        mask[grp] <= 1'b1;
    end
  end

  always_comb begin
    scan_vec = act[out_bank] & ~mask;
    found    = 1'b0;
    lo       = '0;
    for (int i = NG - 1; i >= 0; i--) begin
      if (scan_vec[i]) begin
        found = 1'b1;
        lo    = GRP_W'(i);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grp_nx     = grp;
    idx_nx     = idx;
    fl_we      = 1'b0;
    mask_set   = 1'b0;
    neuron_vld = 1'b0;
    adv        = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (swap)
          state_nx = S_SCAN;
      end
      S_SCAN: begin
        if (enable && !out_busy) begin
          if (found) begin
            grp_nx   = lo;
            idx_nx   = '0;
            state_nx = S_RD;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_RD: begin
        if (enable)
          state_nx = S_PRES;
      end
      S_PRES: begin
        if (enable) begin
          if ((SKIP_ZERO != 0) && (fl_data == '0)) begin
            adv = 1'b1;
          end else begin
            neuron_vld = 1'b1;
            adv        = neuron_rdy;
          end
          if (adv) begin
            fl_we = 1'b1;
            if (idx == '1) begin
              mask_set = 1'b1;
              state_nx = S_SCAN;
            end else begin
              idx_nx   = idx + 1'b1;
              state_nx = S_RD;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (clear_act) begin
      state_nx   = S_DONE;
      fl_we      = 1'b0;
      mask_set   = 1'b0;
      neuron_vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      grp   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      grp   <= grp_nx;
      idx   <= idx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt    <= '0;
      clr_fin    <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (!clear_act) begin
        clr_cnt <= '0;
        clr_fin <= 1'b0;
      end else if (!clr_fin) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1) begin
          clr_fin    <= 1'b1;
          clear_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucaspian_dendrite_multi.sv
// Bench for ucaspian_dendrite_multi: saturating/skip instance and
// wrapping/no-skip instance share stimulus; checked against a sum model.
module tb_ucaspian_dendrite_multi;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              clear_act;
  logic              next_step;
  logic [7:0]        dend_addr;
  logic [8:0]        dend_charge;
  logic              dend_vld;
  logic              neuron_rdy;

  logic              clear_done_a, step_done_a, step_err_a, dend_rdy_a;
  logic [7:0]        neuron_addr_a;
  logic signed [15:0] neuron_charge_a;
  logic              neuron_vld_a;
  logic              clear_done_b, step_done_b, step_err_b, dend_rdy_b;
  logic [7:0]        neuron_addr_b;
  logic signed [15:0] neuron_charge_b;
  logic              neuron_vld_b;

  always #5 clk = ~clk;

  ucaspian_dendrite_multi u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_act(clear_act), .clear_done(clear_done_a),
    .next_step(next_step), .step_done(step_done_a),
    .step_err(step_err_a), .dend_addr(dend_addr),
    .dend_charge(dend_charge), .dend_vld(dend_vld),
    .dend_rdy(dend_rdy_a), .neuron_addr(neuron_addr_a),
    .neuron_charge(neuron_charge_a), .neuron_vld(neuron_vld_a),
    .neuron_rdy(neuron_rdy)
  );

  ucaspian_dendrite_multi #(.SATURATE(0), .SKIP_ZERO(0)) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_act(clear_act), .clear_done(clear_done_b),
    .next_step(next_step), .step_done(step_done_b),
    .step_err(step_err_b), .dend_addr(dend_addr),
    .dend_charge(dend_charge), .dend_vld(dend_vld),
    .dend_rdy(dend_rdy_b), .neuron_addr(neuron_addr_b),
    .neuron_charge(neuron_charge_b), .neuron_vld(neuron_vld_b),
    .neuron_rdy(neuron_rdy)
  );

  typedef struct {
    int addr;
    int val;
  } xfer_t;

  typedef struct {
    int addr;
    int c1;
    int n1;
    int c2;
    int n2;
    int exp_a;
    int exp_b;
  } vec_t;

  xfer_t exp_a[$], exp_b[$], got_a[$], got_b[$];
  int    cur_a[256];
  int    cur_b[256];
  bit    touched[256];
  int    tests = 0;
  int    fails = 0;
  bit    hold = 1'b0;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    neuron_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      neuron_rdy = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && enable && neuron_rdy) begin
        if (neuron_vld_a)
          got_a.push_back(xfer_t'{int'(neuron_addr_a), int'(neuron_charge_a)});
        if (neuron_vld_b)
          got_b.push_back(xfer_t'{int'(neuron_addr_b), int'(neuron_charge_b)});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input int a, input int c);
    int n = 0;
    dend_addr   = 8'(a);
    dend_charge = 9'(c);
    dend_vld    = 1'b1;
    while (!(dend_rdy_a && dend_rdy_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("send_rdy", int'(dend_rdy_a), 1);
    end else begin
      cur_a[a]   = sat16(cur_a[a] + c);
      cur_b[a]   = wrap16(cur_b[a] + c);
      touched[a] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    dend_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(step_done_a && step_done_b) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_step_done", int'(step_done_a && step_done_b), 1);
  endtask

  // Expected flush order: active groups ascending, entries ascending.
  task automatic build_exp();
    exp_a.delete();
    exp_b.delete();
    for (int g = 0; g < 16; g++) begin
      bit on = 1'b0;
      for (int e = 0; e < 16; e++)
        if (touched[g*16+e]) on = 1'b1;
      if (on) begin
        for (int e = 0; e < 16; e++) begin
          int a = g * 16 + e;
          if (cur_a[a] != 0) exp_a.push_back(xfer_t'{a, cur_a[a]});
          exp_b.push_back(xfer_t'{a, cur_b[a]});
        end
      end
    end
    for (int a = 0; a < 256; a++) begin
      cur_a[a]   = 0;
      cur_b[a]   = 0;
      touched[a] = 1'b0;
    end
  endtask

  task automatic swap_step();
    build_exp();
    got_a.delete();
    got_b.delete();
    next_step = 1'b1;
    @(negedge clk);
    next_step = 1'b0;
  endtask

  task automatic cmp_lists(input string tag);
    chk({tag, "_cnt_a"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk({tag, "_addr_a"}, got_a[i].addr, exp_a[i].addr);
      chk({tag, "_val_a"}, got_a[i].val, exp_a[i].val);
    end
    chk({tag, "_cnt_b"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      chk({tag, "_addr_b"}, got_b[i].addr, exp_b[i].addr);
      chk({tag, "_val_b"}, got_b[i].val, exp_b[i].val);
    end
  endtask

  task automatic do_step(input string tag);
    wait_done();
    swap_step();
    wait_done();
    cmp_lists(tag);
  endtask

  task automatic send_batch(input int n);
    for (int k = 0; k < n; k++) begin
      int a = int'($urandom_range(0, 5)) * 37 + int'($urandom_range(0, 2)) * 5;
      int c = int'($urandom_range(0, 511)) - 256;
      send(a, c);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{17, 5, 1, -3, 1, 2, 2};
    tbl[1] = '{200, 255, 4, 0, 0, 1020, 1020};
    tbl[2] = '{3, 255, 200, 0, 0, 32767, -14536};
    tbl[3] = '{9, -256, 200, 0, 0, -32768, 14336};
    tbl[4] = '{100, 255, 150, -256, 100, 7167, 12650};

    for (int a = 0; a < 256; a++) begin
      cur_a[a] = 0;
      cur_b[a] = 0;
      touched[a] = 1'b0;
    end
    reset = 1'b1; enable = 1'b1; clear_act = 1'b0; next_step = 1'b0;
    dend_addr = '0; dend_charge = '0; dend_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dend_rdy", int'(dend_rdy_a), 0);
    chk("rst_neuron_vld", int'(neuron_vld_a | neuron_vld_b), 0);
    chk("rst_step_done", int'(step_done_a & step_done_b), 1);
    chk("rst_step_err", int'(step_err_a | step_err_b), 0);
    chk("rst_clear_done", int'(clear_done_a | clear_done_b), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_dend_rdy", int'(dend_rdy_a & dend_rdy_b), 1);

    begin
      int pa = 0;
      int pb = 0;
      clear_act = 1'b1;
      for (int i = 0; i < 260; i++) begin
        @(negedge clk);
        if (i == 0) chk("clear_dend_rdy", int'(dend_rdy_a), 0);
        if (clear_done_a) pa++;
        if (clear_done_b) pb++;
      end
      clear_act = 1'b0;
      @(negedge clk);
      chk("clear_done_pulses_a", pa, 1);
      chk("clear_done_pulses_b", pb, 1);
      do_step("empty");
      chk("empty_step_done", int'(step_done_a), 1);
    end

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < tbl[r].n1; k++) send(tbl[r].addr, tbl[r].c1);
      for (int k = 0; k < tbl[r].n2; k++) send(tbl[r].addr, tbl[r].c2);
      idle();
      do_step("row");
      chk("row_cnt_a", got_a.size(), 1);
      if (got_a.size() > 0) begin
        chk("row_addr_a", got_a[0].addr, tbl[r].addr);
        chk("row_val_a", got_a[0].val, tbl[r].exp_a);
      end
      chk("row_cnt_b", got_b.size(), 16);
      if (got_b.size() == 16)
        chk("row_val_b", got_b[tbl[r].addr % 16].val, tbl[r].exp_b);
    end

    send(0, 7); send(15, -9); send(16, 1); send(40, 4); send(40, -4);
    idle();
    do_step("skip");
    chk("skip_cnt_a", got_a.size(), 3);
    chk("skip_cnt_b", got_b.size(), 48);

    send(50, 10); send(60, -20); send(70, 30);
    idle();
    wait_done();
    hold = 1'b1;
    swap_step();
    begin
      int n = 0;
      int sa;
      int sc;
      while (!neuron_vld_a && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("stall_vld", int'(neuron_vld_a), 1);
      sa = int'(neuron_addr_a);
      sc = int'(neuron_charge_a);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (i == 3) next_step = 1'b1;
        if (i == 4) begin
          next_step = 1'b0;
          chk("step_err_a", int'(step_err_a), 1);
          chk("step_err_b", int'(step_err_b), 1);
        end
        if (i == 5) chk("step_err_low", int'(step_err_a), 0);
        chk("stall_addr", int'(neuron_addr_a), sa);
        chk("stall_charge", int'(neuron_charge_a), sc);
      end
      hold = 1'b0;
      wait_done();
      cmp_lists("stall");
    end

    send_batch(40);
    wait_done();
    for (int s = 0; s < 4; s++) begin
      swap_step();
      if (s < 3) send_batch(40);
      wait_done();
      cmp_lists("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
